// File: rtl/gpio_debounce_pkg.sv
// Shared constants and helpers for the GPIO switch debouncer.
//
// Contents:
//   DEBOUNCE_TICK_DIV_DEFAULT     - clock cycles per sample tick (1 ms at 50 MHz)
//   DEBOUNCE_STABLE_TICKS_DEFAULT - consecutive differing ticks before a flip
//   TB_TICK_DIV / TB_STABLE_TICKS - short values for simulation builds
//   cnt_width()                   - counter width helper (at least 1 bit)
package gpio_debounce_pkg;

    localparam int DEBOUNCE_TICK_DIV_DEFAULT     = 50000;
    localparam int DEBOUNCE_STABLE_TICKS_DEFAULT = 8;

    localparam int TB_TICK_DIV     = 4;
    localparam int TB_STABLE_TICKS = 3;

    // Width needed to count 0..n-1; a one-state counter still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_input_debouncer_if.sv
// Signal bundle between the board switch pins and the SoC GPIO read path.
//
// Signals:
//   io_raw        - raw asynchronous switch levels
//   io_debounced  - filtered levels (feeds io_gpioA_read)
//   io_rise       - one-cycle 0->1 event per bit
//   io_fall       - one-cycle 1->0 event per bit
//   io_changed    - any rise or fall this cycle
//   io_eventClear - per-bit clear of sticky event flags
//   io_events     - sticky event flags (zero unless GPIO_DEBOUNCE_EVENT_LATCH_EN)
//
// Modports: master = the debouncer, slave = the consumer (SoC / pins side).
interface gpio_input_debouncer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] io_raw;
    logic [WIDTH-1:0] io_debounced;
    logic [WIDTH-1:0] io_rise;
    logic [WIDTH-1:0] io_fall;
    logic             io_changed;
    logic [WIDTH-1:0] io_eventClear;
    logic [WIDTH-1:0] io_events;

    modport master (
        input  io_raw,
        input  io_eventClear,
        output io_debounced,
        output io_rise,
        output io_fall,
        output io_changed,
        output io_events
    );

    modport slave (
        output io_raw,
        output io_eventClear,
        input  io_debounced,
        input  io_rise,
        input  io_fall,
        input  io_changed,
        input  io_events
    );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One-bit switch conditioner: two-flop synchroniser, stability counter,
// filtered level flop and registered rise/fall pulses.
//
// Ports:
//   io_mainClk - SoC clock
//   io_reset   - synchronous active-high reset
//   tick       - shared sample strobe from the top-level prescaler
//   raw        - asynchronous switch input
//   level      - filtered level
//   rise/fall  - one-cycle pulses, aligned with the first cycle of the new level
module gpio_debounce_bit
    import gpio_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT
) (
    input  logic io_mainClk,
    input  logic io_reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            // Stage p0/p1: metastability synchroniser; only sync_p1 is used.
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            // Stage p2: stability filter and level/pulse registers.
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_p1 == level) begin
                // Any return to the current level restarts the count,
                // independent of tick, so bounce never accumulates.
                cnt <= '0;
            end else if (tick && cnt == LAST) begin
                level <= sync_p1;
                cnt   <= '0;
                rise  <= sync_p1;
                fall  <= ~sync_p1;
            end else if (tick) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_input_debouncer.sv
// Debounces the Basys3 slide switches before they reach the Murax GPIO read
// bus. Each bit gets its own synchroniser and stability counter; all bits
// share one sample-tick prescaler.
//
// Ports:
//   io_mainClk - SoC clock (50 MHz)
//   io_reset   - synchronous active-high reset
//   pins       - gpio_input_debouncer_if.master bundle (raw in, filtered
//                level, rise/fall/changed events, optional sticky events)
//
// Build option: define GPIO_DEBOUNCE_EVENT_LATCH_EN to enable the sticky
// io_events flags with per-bit io_eventClear. Without it io_events is 0 and
// io_eventClear is ignored.
module gpio_input_debouncer
    import gpio_debounce_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = DEBOUNCE_TICK_DIV_DEFAULT,
    parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS_DEFAULT
) (
    input logic                  io_mainClk,
    input logic                  io_reset,
    gpio_input_debouncer_if.master pins
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    prescale;
    logic             tick;
    logic [WIDTH-1:0] level_v;
    logic [WIDTH-1:0] rise_v;
    logic [WIDTH-1:0] fall_v;

    // With TICK_DIV == 1 the counter sits at 0 == PRE_LAST: tick every cycle.
    assign tick = (prescale == PRE_LAST);

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .io_mainClk(io_mainClk),
            .io_reset  (io_reset),
            .tick      (tick),
            .raw       (pins.io_raw[i]),
            .level     (level_v[i]),
            .rise      (rise_v[i]),
            .fall      (fall_v[i])
        );
    end

    assign pins.io_debounced = level_v;
    assign pins.io_rise      = rise_v;
    assign pins.io_fall      = fall_v;
    assign pins.io_changed   = |(rise_v | fall_v);

`ifdef GPIO_DEBOUNCE_EVENT_LATCH_EN
    logic [WIDTH-1:0] events_q;

    // A new event outranks a clear arriving in the same cycle.
    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            events_q <= '0;
        end else begin
            events_q <= (events_q & ~pins.io_eventClear) | rise_v | fall_v;
        end
    end

    assign pins.io_events = events_q;
`else
    logic unused_event_clear;
    assign unused_event_clear = ^pins.io_eventClear;
    assign pins.io_events     = '0;
`endif

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Directed bench for gpio_input_debouncer with TICK_DIV=4, STABLE_TICKS=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gpio_input_debouncer;
    import gpio_debounce_pkg::*;

`ifdef GPIO_DEBOUNCE_EVENT_LATCH_EN
    localparam logic LATCH = 1'b1;
`else
    localparam logic LATCH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    gpio_input_debouncer_if #(.WIDTH(16)) dif ();

    gpio_input_debouncer #(
        .WIDTH       (16),
        .TICK_DIV    (TB_TICK_DIV),
        .STABLE_TICKS(TB_STABLE_TICKS)
    ) dut (
        .io_mainClk(clk),
        .io_reset  (rst),
        .pins      (dif.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Step falling edges until a rise (rising=1) or fall event hits mask.
    // n is the number of clock edges waited; budget+1 means timeout.
    task automatic wait_evt(input logic rising, input logic [15:0] mask,
                            input int budget, output int n);
        n = budget + 1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (((rising ? dif.io_rise : dif.io_fall) & mask) != 16'h0) begin
                n = k;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic flag;
        logic [15:0] rv;

        dif.io_raw        = 16'hFFFF;
        dif.io_eventClear = 16'h0000;

        // Reset held with all switches high
        repeat (3) @(negedge clk);
        check_eq("rst_deb",     dif.io_debounced, 0);
        check_eq("rst_rise",    dif.io_rise,      0);
        check_eq("rst_fall",    dif.io_fall,      0);
        check_eq("rst_changed", dif.io_changed,   0);
        check_eq("rst_events",  dif.io_events,    0);
        rst = 1'b0;
        wait_evt(1'b1, 16'hFFFF, 30, n);
        check_eq("rst_rise_lat", n, 12);
        check_eq("rst_rise_val", dif.io_rise,      16'hFFFF);
        check_eq("rst_deb_val",  dif.io_debounced, 16'hFFFF);
        check_eq("rst_chg_val",  dif.io_changed,   1);
        check_eq("rst_fall_val", dif.io_fall,      0);
        @(negedge clk);
        check_eq("rst_rise_1cyc", dif.io_rise,    0);
        check_eq("rst_chg_1cyc",  dif.io_changed, 0);

        // All switches low: every bit falls together
        dif.io_raw = 16'h0000;
        wait_evt(1'b0, 16'hFFFF, 20, n);
        check_eq("fall_all_lat", (n >= 11 && n <= 15), 1);
        check_eq("fall_all_val", dif.io_fall,      16'hFFFF);
        check_eq("fall_all_deb", dif.io_debounced, 16'h0000);
        repeat (3) @(negedge clk);

        // Clean edge on bit 0
        dif.io_raw[0] = 1'b1;
        wait_evt(1'b1, 16'h0001, 20, n);
        check_eq("clean_lat",  (n >= 11 && n <= 15), 1);
        check_eq("clean_rise", dif.io_rise,      16'h0001);
        check_eq("clean_deb",  dif.io_debounced, 16'h0001);
        check_eq("clean_fall", dif.io_fall,      0);
        @(negedge clk);
        check_eq("clean_rise_1cyc", dif.io_rise, 0);
        check_eq("clean_fall_post", dif.io_fall, 0);

        // Bounce on bit 3: 5-cycle toggles never last three ticks
        flag = 1'b0;
        for (int k = 0; k < 12; k++) begin
            dif.io_raw[3] = ~dif.io_raw[3];
            repeat (5) begin
                @(negedge clk);
                if (dif.io_debounced[3] || dif.io_rise[3]) flag = 1'b1;
            end
        end
        check_eq("bounce_hold", flag, 0);
        dif.io_raw[3] = 1'b1;
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (dif.io_rise[3]) cnt++;
        end
        check_eq("bounce_one_rise", cnt, 1);
        check_eq("bounce_deb", dif.io_debounced, 16'h0009);

        // Glitch on bit 7: six cycles high is too short
        flag = 1'b0;
        dif.io_raw[7] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (dif.io_debounced[7] || dif.io_rise[7]) flag = 1'b1;
        end
        dif.io_raw[7] = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (dif.io_debounced[7] || dif.io_rise[7]) flag = 1'b1;
        end
        check_eq("glitch_ignored", flag, 0);

        // Back to all zero, then four bits rise together
        dif.io_raw = 16'h0000;
        wait_evt(1'b0, 16'h0009, 20, n);
        check_eq("clear_fall_val", dif.io_fall, 16'h0009);
        repeat (4) @(negedge clk);
        check_eq("clear_deb", dif.io_debounced, 0);
        dif.io_raw = 16'h00F0;
        cnt = 0;
        rv  = 16'h0000;
        repeat (25) begin
            @(negedge clk);
            if (dif.io_changed) cnt++;
            if (dif.io_rise != 16'h0000 && rv == 16'h0000) rv = dif.io_rise;
        end
        check_eq("simul_changed_once", cnt, 1);
        check_eq("simul_rise",         rv,  16'h00F0);
        check_eq("simul_deb",          dif.io_debounced, 16'h00F0);

        // Reset in the middle of a count on bit 8
        dif.io_raw[8] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_deb",    dif.io_debounced, 0);
        check_eq("midrst_events", dif.io_events,    0);
        rst = 1'b0;
        dif.io_raw[8] = 1'b0;
        wait_evt(1'b1, 16'hFFFF, 30, n);
        check_eq("midrst_relat", n, 12);
        check_eq("midrst_rise",  dif.io_rise, 16'h00F0);
        repeat (3) @(negedge clk);

        // Sticky events on bit 2
        dif.io_eventClear = 16'hFFFF;
        @(negedge clk);
        dif.io_eventClear = 16'h0000;
        check_eq("ev_cleared", dif.io_events, 0);
        dif.io_raw[2] = 1'b1;
        wait_evt(1'b1, 16'h0004, 20, n);
        check_eq("ev_b2_rise_lat", (n >= 11 && n <= 15), 1);
        @(negedge clk);
        dif.io_eventClear = 16'hFFFF;
        @(negedge clk);
        dif.io_eventClear = 16'h0000;
        check_eq("ev_cleared2", dif.io_events, 0);
        dif.io_raw[2] = 1'b0;
        wait_evt(1'b0, 16'h0004, 20, n);
        check_eq("ev_b2_fall", dif.io_fall, 16'h0004);
        @(negedge clk);
        check_eq("ev_b2_set", dif.io_events, {13'h0, LATCH, 2'b00});
        repeat (5) @(negedge clk);
        check_eq("ev_b2_sticky", dif.io_events, {13'h0, LATCH, 2'b00});
        dif.io_eventClear = 16'h0004;
        @(negedge clk);
        dif.io_eventClear = 16'h0000;
        check_eq("ev_b2_clr", dif.io_events, 0);
        dif.io_raw[2] = 1'b1;
        wait_evt(1'b1, 16'h0004, 20, n);
        dif.io_eventClear = 16'h0004;
        @(negedge clk);
        dif.io_eventClear = 16'h0000;
        check_eq("ev_set_wins", dif.io_events, {13'h0, LATCH, 2'b00});
        @(negedge clk);
        check_eq("ev_set_hold", dif.io_events, {13'h0, LATCH, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
